// File: rtl/axi_ram_slave.sv
// AXI4 RAM slave: one word-organised RAM with independent write and read burst engines.

package axi_ram_slave_pkg;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // master -> slave bundle
  typedef struct packed {
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  b_ready;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  r_ready;
  } axi_mosi_t;

  // slave -> master bundle
  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
  } axi_miso_t;
endpackage

// Byte-strobed RAM with a registered read port; a same-cycle read sees pre-write data.
module axi_ram_slave_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_widx,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [DATA_W/8-1:0]          i_wstrb,
  input  logic                         i_re,
  input  logic [$clog2(MEM_WORDS)-1:0] i_ridx,
  output logic [DATA_W-1:0]            o_rdata
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] ram [0:MEM_WORDS-1];
  logic [DATA_W-1:0] r_rdata;

  // Lane-masked write; array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) ram[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; held between fetches so the beat stays stable under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= ram[i_ridx];
  end

  assign o_rdata = r_rdata;
endmodule

module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W    = AXI_ADDR_W,
  parameter int unsigned DATA_W    = AXI_DATA_W,
  parameter int unsigned ID_W      = AXI_ID_W,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_mosi_t in_mosi_i,
  output axi_miso_t in_miso_o
);
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // ---------------- write engine ----------------
  w_state_t          r_w_state, w_w_state_nxt;
  logic              r_aw_ready, r_w_ready, r_b_valid;
  logic [ID_W-1:0]   r_b_id;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen, r_wcnt;
  logic [1:0]        r_wburst;
  logic              w_aw_hs, w_w_hs;
  logic              w_aw_ready_nxt, w_w_ready_nxt, w_b_valid_nxt;
  logic [ADDR_W-1:0] w_waddr_inc;

  assign w_waddr_inc = (r_wburst == BURST_FIXED) ? r_waddr : r_waddr + ADDR_W'(STRB_W);

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_w_state <= W_IDLE;
    else       r_w_state <= w_w_state_nxt;
  end

  // Write next-state, handshakes and next values of the registered channel flags.
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (in_mosi_i.aw_valid && r_aw_ready) begin
          w_aw_hs       = 1'b1;
          w_w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (in_mosi_i.w_valid && r_w_ready) begin
          w_w_hs = 1'b1;
          if (in_mosi_i.w_last || (r_wcnt == r_wlen)) w_w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (in_mosi_i.b_ready && r_b_valid) w_w_state_nxt = W_IDLE;
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
    w_aw_ready_nxt = (w_w_state_nxt == W_IDLE);
    w_w_ready_nxt  = (w_w_state_nxt == W_DATA);
    w_b_valid_nxt  = (w_w_state_nxt == W_RESP);
  end

  // Write channel outputs and burst bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= '0;
      r_waddr    <= '0;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_wburst   <= BURST_INCR;
    end else begin
      r_aw_ready <= w_aw_ready_nxt;
      r_w_ready  <= w_w_ready_nxt;
      r_b_valid  <= w_b_valid_nxt;
      if (w_aw_hs) begin
        r_b_id   <= ID_W'(in_mosi_i.aw_id);
        r_waddr  <= ADDR_W'(in_mosi_i.aw_addr);
        r_wlen   <= in_mosi_i.aw_len;
        r_wburst <= in_mosi_i.aw_burst;
        r_wcnt   <= '0;
      end else if (w_w_hs) begin
        r_waddr <= w_waddr_inc;
        r_wcnt  <= 8'(r_wcnt + 8'd1);
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t          r_r_state, w_r_state_nxt;
  logic              r_ar_ready, r_r_valid, r_r_last;
  logic [ID_W-1:0]   r_r_id;
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_rlen, r_rcnt;
  logic [1:0]        r_rburst;
  logic              w_ar_hs, w_r_hs, w_rd_fetch;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_ar_ready_nxt, w_r_valid_nxt;
  logic [ADDR_W-1:0] w_raddr_inc;
  logic [DATA_W-1:0] w_rdata;

  assign w_raddr_inc = (r_rburst == BURST_FIXED) ? r_raddr : r_raddr + ADDR_W'(STRB_W);

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_r_state <= R_IDLE;
    else       r_r_state <= w_r_state_nxt;
  end

  // Read next-state and fetch control; the next beat is fetched on the current beat's handshake.
  always_comb begin
    w_r_state_nxt = r_r_state;
    w_ar_hs       = 1'b0;
    w_r_hs        = 1'b0;
    w_rd_fetch    = 1'b0;
    w_rd_idx      = w_raddr_inc[BYTE_SHIFT +: IDX_W];
    case (r_r_state)
      R_IDLE: begin
        if (in_mosi_i.ar_valid && r_ar_ready) begin
          w_ar_hs       = 1'b1;
          w_rd_fetch    = 1'b1;
          w_rd_idx      = in_mosi_i.ar_addr[BYTE_SHIFT +: IDX_W];
          w_r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (in_mosi_i.r_ready && r_r_valid) begin
          w_r_hs = 1'b1;
          if (r_r_last) w_r_state_nxt = R_IDLE;
          else          w_rd_fetch    = 1'b1;
        end
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
    w_ar_ready_nxt = (w_r_state_nxt == R_IDLE);
    w_r_valid_nxt  = (w_r_state_nxt == R_DATA);
  end

  // Read channel outputs and burst bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_r_last   <= 1'b0;
      r_r_id     <= '0;
      r_raddr    <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_rburst   <= BURST_INCR;
    end else begin
      r_ar_ready <= w_ar_ready_nxt;
      r_r_valid  <= w_r_valid_nxt;
      if (w_ar_hs) begin
        r_r_id   <= ID_W'(in_mosi_i.ar_id);
        r_raddr  <= ADDR_W'(in_mosi_i.ar_addr);
        r_rlen   <= in_mosi_i.ar_len;
        r_rburst <= in_mosi_i.ar_burst;
        r_rcnt   <= '0;
        r_r_last <= (in_mosi_i.ar_len == 8'd0);
      end else if (w_r_hs) begin
        if (r_r_last) begin
          r_r_last <= 1'b0;
        end else begin
          r_raddr  <= w_raddr_inc;
          r_rcnt   <= 8'(r_rcnt + 8'd1);
          r_r_last <= (8'(r_rcnt + 8'd1) == r_rlen);
        end
      end
    end
  end

  axi_ram_slave_mem #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) coupled_ram (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_w_hs),
    .i_widx  (r_waddr[BYTE_SHIFT +: IDX_W]),
    .i_wdata (DATA_W'(in_mosi_i.w_data)),
    .i_wstrb (STRB_W'(in_mosi_i.w_strb)),
    .i_re    (w_rd_fetch),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rdata)
  );

  // Transfer size is fixed at full width, so the size fields are not decoded.
  logic w_unused_size;
  assign w_unused_size = ^{in_mosi_i.aw_size, in_mosi_i.ar_size};

  // Pack the registered channel state onto the slave bundle; responses are always OKAY.
  always_comb begin
    in_miso_o          = '0;
    in_miso_o.aw_ready = r_aw_ready;
    in_miso_o.w_ready  = r_w_ready;
    in_miso_o.b_id     = AXI_ID_W'(r_b_id);
    in_miso_o.b_resp   = 2'b00;
    in_miso_o.b_valid  = r_b_valid;
    in_miso_o.ar_ready = r_ar_ready;
    in_miso_o.r_id     = AXI_ID_W'(r_r_id);
    in_miso_o.r_data   = AXI_DATA_W'(w_rdata);
    in_miso_o.r_resp   = 2'b00;
    in_miso_o.r_last   = r_r_last;
    in_miso_o.r_valid  = r_r_valid;
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: single/burst/FIXED writes, stalled reads, concurrency, reset mid-burst.
module tb_axi_ram_slave;
  import axi_ram_slave_pkg::*;

  logic      clk;
  logic      rst;
  axi_mosi_t mosi;
  axi_miso_t miso;

  logic [3:0]  aw_id_d, ar_id_d;
  logic [31:0] aw_addr_d, ar_addr_d;
  logic [7:0]  aw_len_d, ar_len_d;
  logic [1:0]  aw_burst_d, ar_burst_d;
  logic        aw_valid_d, ar_valid_d;
  logic [31:0] w_data_d;
  logic [3:0]  w_strb_d;
  logic        w_last_d, w_valid_d, b_ready_d, r_ready_d;

  logic [31:0] beat_data [0:15];
  logic [31:0] exp_data  [0:15];

  int n_checks;
  int n_fail;

  axi_ram_slave dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_mosi_i (mosi),
    .in_miso_o (miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  always_comb begin
    mosi          = '0;
    mosi.aw_id    = aw_id_d;
    mosi.aw_addr  = aw_addr_d;
    mosi.aw_len   = aw_len_d;
    mosi.aw_size  = 3'd2;
    mosi.aw_burst = aw_burst_d;
    mosi.aw_valid = aw_valid_d;
    mosi.w_data   = w_data_d;
    mosi.w_strb   = w_strb_d;
    mosi.w_last   = w_last_d;
    mosi.w_valid  = w_valid_d;
    mosi.b_ready  = b_ready_d;
    mosi.ar_id    = ar_id_d;
    mosi.ar_addr  = ar_addr_d;
    mosi.ar_len   = ar_len_d;
    mosi.ar_size  = 3'd2;
    mosi.ar_burst = ar_burst_d;
    mosi.ar_valid = ar_valid_d;
    mosi.r_ready  = r_ready_d;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input int nbeats,
                           input logic [1:0] burst, input logic [3:0] strb, input logic [3:0] id);
    int n;
    @(negedge clk);
    aw_id_d = id; aw_addr_d = addr; aw_len_d = 8'(len); aw_burst_d = burst; aw_valid_d = 1'b1;
    n = 0;
    while (!miso.aw_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_eq("aw_timeout", 32'd0, 32'd1);
    @(negedge clk);
    aw_valid_d = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      w_data_d = beat_data[i]; w_strb_d = strb; w_last_d = (i == nbeats - 1); w_valid_d = 1'b1;
      n = 0;
      while (!miso.w_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check_eq("w_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    w_valid_d = 1'b0; w_last_d = 1'b0;
    b_ready_d = 1'b1;
    n = 0;
    while (!miso.b_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_eq("b_timeout", 32'd0, 32'd1);
    check_eq("b_id", 32'(miso.b_id), 32'(id));
    check_eq("b_resp", 32'(miso.b_resp), 32'd0);
    @(negedge clk);
    b_ready_d = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id, input bit toggle);
    int n;
    int beat;
    int cyc;
    logic rr;
    @(negedge clk);
    ar_id_d = id; ar_addr_d = addr; ar_len_d = 8'(len); ar_burst_d = burst; ar_valid_d = 1'b1;
    n = 0;
    while (!miso.ar_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_eq("ar_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ar_valid_d = 1'b0;
    check_eq("r_first_valid", 32'(miso.r_valid), 32'd1);
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 200) begin
      rr = toggle ? ((cyc % 2) == 1) : 1'b1;
      r_ready_d = rr;
      if (miso.r_valid) begin
        check_eq("r_data", miso.r_data, exp_data[beat]);
        check_eq("r_last", 32'(miso.r_last), 32'(beat == len));
        if (rr) begin
          check_eq("r_id", 32'(miso.r_id), 32'(id));
          check_eq("r_resp", 32'(miso.r_resp), 32'd0);
          beat++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    r_ready_d = 1'b0;
    if (beat <= len) check_eq("r_timeout", 32'd0, 32'd1);
    check_eq("r_valid_end", 32'(miso.r_valid), 32'd0);
    check_eq("ar_ready_end", 32'(miso.ar_ready), 32'd1);
    if (!toggle) check_eq("r_no_bubble", 32'(cyc), 32'(len + 1));
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] data);
    beat_data[0] = data;
    axi_write(addr, 0, 1, BURST_INCR, 4'hF, 4'd1);
  endtask

  task automatic read1(input logic [31:0] addr, input logic [31:0] exp);
    exp_data[0] = exp;
    axi_read(addr, 0, BURST_INCR, 4'd2, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    aw_id_d = '0; aw_addr_d = '0; aw_len_d = '0; aw_burst_d = BURST_INCR; aw_valid_d = 1'b0;
    ar_id_d = '0; ar_addr_d = '0; ar_len_d = '0; ar_burst_d = BURST_INCR; ar_valid_d = 1'b0;
    w_data_d = '0; w_strb_d = '0; w_last_d = 1'b0; w_valid_d = 1'b0;
    b_ready_d = 1'b0; r_ready_d = 1'b0;
    rst = 1'b1;

    // Reset state, then readies rise one edge after release.
    repeat (3) @(negedge clk);
    check_eq("rst_aw_ready", 32'(miso.aw_ready), 32'd0);
    check_eq("rst_ar_ready", 32'(miso.ar_ready), 32'd0);
    check_eq("rst_b_valid", 32'(miso.b_valid), 32'd0);
    check_eq("rst_r_valid", 32'(miso.r_valid), 32'd0);
    check_eq("rst_r_data", miso.r_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_aw_ready", 32'(miso.aw_ready), 32'd1);
    check_eq("post_rst_ar_ready", 32'(miso.ar_ready), 32'd1);

    // Preload
    write1(32'h10,  32'hCAFEF00D);
    write1(32'h20,  32'h11223344);
    write1(32'h3C,  32'h5555AAAA);
    write1(32'h44,  32'h6666BBBB);
    write1(32'h208, 32'h12345678);
    write1(32'h500, 32'h0BADF00D);

    // Single read with echoed id
    exp_data[0] = 32'hCAFEF00D;
    axi_read(32'h10, 0, BURST_INCR, 4'd3, 1'b0);

    // Strobed write over an existing word
    beat_data[0] = 32'hDEADBEEF;
    axi_write(32'h20, 0, 1, BURST_INCR, 4'b0101, 4'd5);
    read1(32'h20, 32'h11AD33EF);

    // INCR burst write, then stalled INCR read
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
    axi_write(32'h100, 3, 4, BURST_INCR, 4'hF, 4'd6);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'(i + 1);
    axi_read(32'h100, 3, BURST_INCR, 4'd9, 1'b1);

    // FIXED burst: last beat wins, neighbours untouched
    beat_data[0] = 32'h0000000A; beat_data[1] = 32'h0000000B; beat_data[2] = 32'h0000000C;
    axi_write(32'h40, 2, 3, BURST_FIXED, 4'hF, 4'd2);
    read1(32'h40, 32'h0000000C);
    read1(32'h3C, 32'h5555AAAA);
    read1(32'h44, 32'h6666BBBB);

    // Address wraps modulo RAM size (4096 words = 0x4000 bytes)
    read1(32'h4010, 32'hCAFEF00D);

    // Early w_last ends the burst; the third word is left alone
    beat_data[0] = 32'hA0A0A0A0; beat_data[1] = 32'hB1B1B1B1;
    axi_write(32'h200, 3, 2, BURST_INCR, 4'hF, 4'd4);
    read1(32'h200, 32'hA0A0A0A0);
    read1(32'h204, 32'hB1B1B1B1);
    read1(32'h208, 32'h12345678);

    // Concurrent read and write bursts on disjoint regions
    beat_data[0] = 32'h30303030; beat_data[1] = 32'h31313131;
    for (int i = 0; i < 4; i++) exp_data[i] = 32'(i + 1);
    fork
      axi_write(32'h300, 1, 2, BURST_INCR, 4'hF, 4'd8);
      axi_read(32'h100, 3, BURST_INCR, 4'd1, 1'b0);
    join
    read1(32'h300, 32'h30303030);
    read1(32'h304, 32'h31313131);

    // Same-word write and read fetch on the same edge return the old word
    @(negedge clk);
    aw_id_d = 4'd3; aw_addr_d = 32'h500; aw_len_d = 8'd0; aw_burst_d = BURST_INCR; aw_valid_d = 1'b1;
    check_eq("same_aw_ready", 32'(miso.aw_ready), 32'd1);
    @(negedge clk);
    aw_valid_d = 1'b0;
    check_eq("same_w_ready", 32'(miso.w_ready), 32'd1);
    check_eq("same_ar_ready", 32'(miso.ar_ready), 32'd1);
    w_data_d = 32'h77777777; w_strb_d = 4'hF; w_last_d = 1'b1; w_valid_d = 1'b1;
    ar_id_d = 4'd7; ar_addr_d = 32'h500; ar_len_d = 8'd0; ar_burst_d = BURST_INCR; ar_valid_d = 1'b1;
    @(negedge clk);
    w_valid_d = 1'b0; w_last_d = 1'b0; ar_valid_d = 1'b0;
    check_eq("same_r_valid", 32'(miso.r_valid), 32'd1);
    check_eq("same_r_old", miso.r_data, 32'h0BADF00D);
    check_eq("same_b_valid", 32'(miso.b_valid), 32'd1);
    r_ready_d = 1'b1; b_ready_d = 1'b1;
    @(negedge clk);
    r_ready_d = 1'b0; b_ready_d = 1'b0;
    read1(32'h500, 32'h77777777);

    // Reset during the second beat of a 4-beat read
    @(negedge clk);
    ar_id_d = 4'd2; ar_addr_d = 32'h100; ar_len_d = 8'd3; ar_burst_d = BURST_INCR; ar_valid_d = 1'b1;
    @(negedge clk);
    ar_valid_d = 1'b0; r_ready_d = 1'b1;
    check_eq("mid_beat0", miso.r_data, 32'd1);
    @(negedge clk);
    check_eq("mid_beat1", miso.r_data, 32'd2);
    check_eq("mid_beat1_valid", 32'(miso.r_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_r_valid", 32'(miso.r_valid), 32'd0);
    check_eq("mid_rst_ar_ready", 32'(miso.ar_ready), 32'd0);
    rst = 1'b0; r_ready_d = 1'b0;
    @(negedge clk);
    check_eq("mid_rel_ar_ready", 32'(miso.ar_ready), 32'd1);
    check_eq("mid_rel_r_valid", 32'(miso.r_valid), 32'd0);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'(i + 1);
    axi_read(32'h100, 3, BURST_INCR, 4'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
